reg_write_arbiter: RTL and testbench

Write-port arbiter and pending-write scoreboard for the 8 x 32-bit register file. It shares the file's single write port between the ALU writeback path and the load-return path, and drives the file's write_addr, write_value and write_enable from registered outputs. It also tracks which registers have an issued but uncommitted write, so decode can stall on read-after-write (RAW) hazards. Register 7 is the zero register and is never written.

---
 rtl/reg_write_arbiter_if.sv | 52 +++++
 rtl/reg_write_arbiter.sv | 132 +++++++++++++
 tb/tb_reg_write_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Bundle of signals between the register-file write arbiter and its
// neighbours: the ALU writeback and load-return requesters, the decode
// issue/check ports and the register-file write port.
interface reg_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  localparam int NREG = 1 << ADDR_W;

  // ALU writeback request channel
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;

  // Load-return request channel
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;

  // Decode issue and hazard check
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_addr;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              chk_busy;
  logic [NREG-1:0]   busy_mask;

  // Register-file write port
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_value;
  logic              rf_write_enable;

  // Requester / decode / register-file side
  modport master (
    output alu_valid, alu_addr, alu_data,
    output ld_valid, ld_addr, ld_data,
    output issue_valid, issue_addr, chk_addr1, chk_addr2,
    input  alu_ready, ld_ready, chk_busy, busy_mask,
    input  rf_write_addr, rf_write_value, rf_write_enable
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  ld_valid, ld_addr, ld_data,
    input  issue_valid, issue_addr, chk_addr1, chk_addr2,
    output alu_ready, ld_ready, chk_busy, busy_mask,
    output rf_write_addr, rf_write_value, rf_write_enable
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Write-port arbiter and pending-write scoreboard for the register file.
// The ALU writeback path wins by default; a load that has been denied for
// STARVE_LIMIT consecutive cycles takes priority. The winning write is
// registered and presented to the register file one cycle after the grant.
// The scoreboard marks registers with an issued but uncommitted write so
// decode can stall on read-after-write hazards. The top register is the
// zero register and is never written or marked busy.
module reg_write_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 3,
  parameter int STARVE_LIMIT = 2
) (
  input logic                clk,
  input logic                rst_n,
  reg_write_arbiter_if.slave bus
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(NREG - 1);

  logic [CNT_W-1:0]  starve_cnt;
  logic              load_priority;
  logic              alu_grant;
  logic              ld_grant;
  logic              any_grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_value_q;
  logic              wr_en_q;

  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_next;
  logic              chk1_busy;
  logic              chk2_busy;

  // Grant decision: ALU first unless the load has waited long enough;
  // both readies are forced low while reset is held.
  always_comb begin
    load_priority = bus.ld_valid && (starve_cnt == CNT_MAX);
    alu_grant     = rst_n && bus.alu_valid && !load_priority;
    ld_grant      = rst_n && bus.ld_valid && (!bus.alu_valid || load_priority);
    any_grant     = alu_grant || ld_grant;
  end

  // Select the address and data of whichever requester was granted.
  always_comb begin
    win_addr = bus.alu_addr;
    win_data = bus.alu_data;
    if (ld_grant) begin
      win_addr = bus.ld_addr;
      win_data = bus.ld_data;
    end
  end

  // Count consecutive cycles the load is kept waiting, saturating at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!bus.ld_valid || ld_grant) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Register the winning write; address and value hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      wr_value_q <= '0;
      wr_en_q    <= 1'b0;
    end else if (any_grant) begin
      wr_addr_q  <= win_addr;
      wr_value_q <= win_data;
      wr_en_q    <= (win_addr != ZERO_REG);
    end else begin
      wr_en_q    <= 1'b0;
    end
  end

  // Next scoreboard value: the commit clears first so a same-edge issue wins.
  always_comb begin
    busy_next = busy_q;
    if (wr_en_q) begin
      busy_next[wr_addr_q] = 1'b0;
    end
    if (bus.issue_valid && (bus.issue_addr != ZERO_REG)) begin
      busy_next[bus.issue_addr] = 1'b1;
    end
    busy_next[ZERO_REG] = 1'b0;
  end

  // Scoreboard storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  // Hazard check of both decode sources against the registered mask.
  always_comb begin
    chk1_busy = busy_q[bus.chk_addr1] && (bus.chk_addr1 != ZERO_REG);
    chk2_busy = busy_q[bus.chk_addr2] && (bus.chk_addr2 != ZERO_REG);
  end

  assign bus.alu_ready       = alu_grant;
  assign bus.ld_ready        = ld_grant;
  assign bus.chk_busy        = chk1_busy || chk2_busy;
  assign bus.busy_mask       = busy_q;
  assign bus.rf_write_addr   = wr_addr_q;
  assign bus.rf_write_value  = wr_value_q;
  assign bus.rf_write_enable = wr_en_q;

  // Handshake and zero-register invariants.
  a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_grant && ld_grant));
  a_alu_ready_valid : assert property (@(posedge clk) disable iff (!rst_n)
    alu_grant |-> bus.alu_valid);
  a_ld_ready_valid : assert property (@(posedge clk) disable iff (!rst_n)
    ld_grant |-> bus.ld_valid);
  a_no_zero_write : assert property (@(posedge clk) disable iff (!rst_n)
    wr_en_q |-> (wr_addr_q != ZERO_REG));
  a_zero_never_busy : assert property (@(posedge clk) disable iff (!rst_n)
    !busy_q[ZERO_REG]);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural model of the arbiter, the
// one-cycle write pipeline and the pending-write scoreboard.
module tb_reg_write_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 3;
  localparam int STARVE_LIMIT = 2;

  logic clk;
  logic rst_n;
  int   total_checks;
  int   bad_checks;

  reg_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_write_arbiter #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: the write due at the register file next cycle, the set of
  // registers with a pending write, and how long the load has been waiting.
  bit          m_we;
  int          m_waddr;
  logic [31:0] m_wval;
  bit          pend[8];
  int          ld_wait;
  bit          last_alu_grant;
  bit          last_ld_grant;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_checks++;
    if (got !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_we = 0;
    m_waddr = 0;
    m_wval = '0;
    for (int i = 0; i < 8; i++) pend[i] = 0;
    ld_wait = 0;
    last_alu_grant = 0;
    last_ld_grant = 0;
  endtask

  task automatic setIdle();
    bus.alu_valid   = 1'b0;
    bus.alu_addr    = '0;
    bus.alu_data    = '0;
    bus.ld_valid    = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    bus.chk_addr1   = '0;
    bus.chk_addr2   = '0;
  endtask

  // Assert reset away from a clock edge, check the reset state, release after the next edge.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_we", bus.rf_write_enable, 0);
    checkOutput("rst_addr", bus.rf_write_addr, 0);
    checkOutput("rst_value", bus.rf_write_value, 0);
    checkOutput("rst_mask", bus.busy_mask, 0);
    checkOutput("rst_alu_ready", bus.alu_ready, 0);
    checkOutput("rst_ld_ready", bus.ld_ready, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Check every output against the model mid-cycle, then advance the model and the clock.
  task automatic runCycle();
    bit         g_alu;
    bit         g_ld;
    logic [7:0] mask;
    bit         exp_chk;
    #3;
    g_ld  = bus.ld_valid && (!bus.alu_valid || ld_wait >= STARVE_LIMIT);
    g_alu = bus.alu_valid && !g_ld;
    for (int i = 0; i < 8; i++) mask[i] = pend[i];
    exp_chk = pend[bus.chk_addr1] || pend[bus.chk_addr2];
    checkOutput("alu_ready", bus.alu_ready, g_alu);
    checkOutput("ld_ready", bus.ld_ready, g_ld);
    checkOutput("chk_busy", bus.chk_busy, exp_chk);
    checkOutput("busy_mask", bus.busy_mask, mask);
    checkOutput("rf_we", bus.rf_write_enable, m_we);
    checkOutput("rf_addr", bus.rf_write_addr, m_waddr);
    checkOutput("rf_value", bus.rf_write_value, m_wval);
    if (m_we) pend[m_waddr] = 0;
    if (bus.issue_valid && bus.issue_addr != 7) pend[bus.issue_addr] = 1;
    if (g_ld) begin
      m_waddr = int'(bus.ld_addr);
      m_wval  = bus.ld_data;
      m_we    = (bus.ld_addr != 7);
    end else if (g_alu) begin
      m_waddr = int'(bus.alu_addr);
      m_wval  = bus.alu_data;
      m_we    = (bus.alu_addr != 7);
    end else begin
      m_we = 0;
    end
    ld_wait = (bus.ld_valid && !g_ld) ? ld_wait + 1 : 0;
    last_alu_grant = g_alu;
    last_ld_grant  = g_ld;
    @(posedge clk);
    #1;
  endtask

  // Random requesters that hold their request until granted, plus random issue/check traffic.
  task automatic applyStimulus();
    if (!bus.alu_valid || last_alu_grant) begin
      bus.alu_valid = ($urandom_range(0, 3) != 0);
      bus.alu_addr  = 3'($urandom_range(0, 7));
      bus.alu_data  = $urandom;
    end
    if (!bus.ld_valid || last_ld_grant) begin
      bus.ld_valid = ($urandom_range(0, 1) != 0);
      bus.ld_addr  = 3'($urandom_range(0, 7));
      bus.ld_data  = $urandom;
    end
    bus.issue_valid = ($urandom_range(0, 2) == 0);
    bus.issue_addr  = 3'($urandom_range(0, 7));
    bus.chk_addr1   = 3'($urandom_range(0, 7));
    bus.chk_addr2   = 3'($urandom_range(0, 7));
  endtask

  initial begin
    int exp_addr[4];
    int ld_regs[3];
    total_checks = 0;
    bad_checks   = 0;
    rst_n = 1'b1;
    setIdle();
    modelReset();
    #2;
    doReset();

    // Single ALU write with a RAW check on its destination.
    setIdle();
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 3'd3;
    runCycle();
    setIdle();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd3;
    bus.alu_data  = 32'hDEADBEEF;
    bus.chk_addr1 = 3'd3;
    runCycle();
    bus.alu_valid = 1'b0;
    checkOutput("single_we", bus.rf_write_enable, 1);
    checkOutput("single_addr", bus.rf_write_addr, 3);
    checkOutput("single_value", bus.rf_write_value, 32'hDEADBEEF);
    checkOutput("single_chk_before", bus.chk_busy, 1);
    runCycle();
    checkOutput("single_mask_after", bus.busy_mask[3], 0);
    checkOutput("single_chk_after", bus.chk_busy, 0);

    // Contention: ALU wins twice, then the starved load, then ALU again.
    exp_addr = '{1, 1, 4, 1};
    setIdle();
    for (int c = 0; c < 4; c++) begin
      bus.alu_valid = 1'b1;
      bus.alu_addr  = 3'd1;
      bus.alu_data  = 32'h100 + 32'(c);
      bus.ld_valid  = 1'b1;
      bus.ld_addr   = 3'd4;
      bus.ld_data   = 32'h44;
      runCycle();
      checkOutput($sformatf("contend_addr%0d", c), bus.rf_write_addr, exp_addr[c]);
    end
    setIdle();
    runCycle();

    // Zero register: handshake completes but nothing is written or marked.
    setIdle();
    bus.alu_valid   = 1'b1;
    bus.alu_addr    = 3'd7;
    bus.alu_data    = 32'hFFFFFFFF;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 3'd7;
    bus.chk_addr1   = 3'd7;
    bus.chk_addr2   = 3'd7;
    runCycle();
    checkOutput("zero_we", bus.rf_write_enable, 0);
    checkOutput("zero_mask", bus.busy_mask, 0);
    checkOutput("zero_chk", bus.chk_busy, 0);
    setIdle();
    runCycle();

    // Set/clear collision on register 5: the new issue keeps it busy.
    setIdle();
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 3'd5;
    runCycle();
    setIdle();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd5;
    bus.alu_data  = 32'h55;
    runCycle();
    setIdle();
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 3'd5;
    runCycle();
    checkOutput("collide_mask5", bus.busy_mask[5], 1);
    setIdle();
    runCycle();
    checkOutput("collide_mask5_hold", bus.busy_mask[5], 1);

    // Back-to-back loads with no bubbles.
    ld_regs = '{1, 2, 6};
    for (int c = 0; c < 3; c++) begin
      setIdle();
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 3'(ld_regs[c]);
      bus.ld_data  = $urandom;
      runCycle();
      checkOutput($sformatf("b2b_we%0d", c), bus.rf_write_enable, 1);
      checkOutput($sformatf("b2b_addr%0d", c), bus.rf_write_addr, ld_regs[c]);
    end
    setIdle();
    runCycle();

    // Reset in the cycle after a grant drops the in-flight write.
    setIdle();
    bus.alu_valid   = 1'b1;
    bus.alu_addr    = 3'd2;
    bus.alu_data    = 32'h11;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 3'd2;
    runCycle();
    bus.ld_valid = 1'b1;
    doReset();
    setIdle();

    // Random traffic with occasional resets.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      applyStimulus();
      runCycle();
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
